// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative RV32M multiply/divide unit.
//
// Purpose:
//   Runs one RV32M operation at a time. Multiplication is a 32-step
//   shift-add on sign-adjusted magnitudes. Division is restoring division
//   that produces one quotient bit per step. The result and the destination
//   register index are presented together with a one-cycle done pulse.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   operation request, sampled only in IDLE
//   funct3    in   0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   dataA     in   rs1 operand
//   dataB     in   rs2 operand
//   addD      in   destination register index
//   busy      out  high while iterating (CALC)
//   done      out  one-cycle pulse, result/addD_out valid
//   result    out  write-back value, held until the next done
//   addD_out  out  addD captured at start, held until the next done
//
// Build option:
//   MULDIV_EARLY_OUT_EN -- when defined, divide-by-zero and signed-overflow
//   operations go straight from IDLE to DONE without iterating.

module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] dataA,
  input  logic [XLEN-1:0] dataB,
  input  logic [4:0]      addD,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      addD_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [5:0]      LAST_ITER = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_reg;
  logic [5:0]        cnt_reg;
  logic [2:0]        op_reg;
  logic [XLEN-1:0]   a_reg;
  logic [XLEN-1:0]   b_reg;
  logic [4:0]        rd_reg;
  logic              sa_reg;
  logic              sb_reg;

  logic [2*XLEN-1:0] prod_reg;
  logic [2*XLEN-1:0] mcand_reg;
  logic [XLEN-1:0]   mplier_reg;
  logic [XLEN-1:0]   rem_reg;
  logic [XLEN-1:0]   quo_reg;
  logic [XLEN-1:0]   dvsr_reg;

  logic [XLEN-1:0]   result_reg;
  logic [4:0]        addD_out_reg;

  // Operand signedness of the incoming request.
  logic            a_sgn_in;
  logic            b_sgn_in;
  logic [XLEN-1:0] mag_a_in;
  logic [XLEN-1:0] mag_b_in;

  assign a_sgn_in = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                    (funct3 == OP_DIV)  || (funct3 == OP_REM);
  assign b_sgn_in = (funct3 == OP_MULH) || (funct3 == OP_DIV) ||
                    (funct3 == OP_REM);
  assign mag_a_in = (a_sgn_in && dataA[XLEN-1]) ? (~dataA + 1'b1) : dataA;
  assign mag_b_in = (b_sgn_in && dataB[XLEN-1]) ? (~dataB + 1'b1) : dataB;

  // One iteration of each datapath, computed combinationally so the final
  // step can feed the result register on the same edge that enters DONE.
  logic [2*XLEN-1:0] prod_next;
  logic [XLEN:0]     rem_shift;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_diff;
  logic [XLEN-1:0]   rem_next;
  logic [XLEN-1:0]   quo_next;

  assign prod_next = mplier_reg[0] ? (prod_reg + mcand_reg) : prod_reg;
  assign rem_shift = {rem_reg, quo_reg[XLEN-1]};
  assign rem_ge    = (rem_shift >= {1'b0, dvsr_reg});
  // When rem_ge holds the true difference is below dvsr_reg, so the low
  // XLEN bits of the wrapped subtraction are exact.
  assign rem_diff  = rem_shift[XLEN-1:0] - dvsr_reg;
  assign rem_next  = rem_ge ? rem_diff : rem_shift[XLEN-1:0];
  assign quo_next  = {quo_reg[XLEN-2:0], rem_ge};

  // Final write-back value. Divide-by-zero and signed overflow are forced
  // explicitly so the result does not depend on the iteration having run.
  function automatic logic [XLEN-1:0] final_result(
    input logic [2:0]        op,
    input logic [XLEN-1:0]   a,
    input logic [XLEN-1:0]   b,
    input logic              sa,
    input logic              sb,
    input logic [2*XLEN-1:0] prod,
    input logic [XLEN-1:0]   quo,
    input logic [XLEN-1:0]   rem
  );
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic              div0;
    logic              ovf;
    prod_s = (sa ^ sb) ? (~prod + 1'b1) : prod;
    quo_s  = (sa ^ sb) ? (~quo + 1'b1) : quo;
    rem_s  = sa ? (~rem + 1'b1) : rem;
    div0   = (b == '0);
    ovf    = ((op == OP_DIV) || (op == OP_REM)) && (a == INT_MIN) && (b == '1);
    case (op)
      OP_MUL:                     final_result = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU,
      OP_MULHU:                   final_result = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            final_result = div0 ? '1 : (ovf ? INT_MIN : quo_s);
      default:                    final_result = div0 ? a : (ovf ? '0 : rem_s);
    endcase
  endfunction

`ifdef MULDIV_EARLY_OUT_EN
  logic special_in;
  assign special_in = funct3[2] &&
                      ((dataB == '0) ||
                       (((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
                        (dataA == INT_MIN) && (dataB == '1)));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      op_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      rd_reg       <= '0;
      sa_reg       <= 1'b0;
      sb_reg       <= 1'b0;
      prod_reg     <= '0;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      dvsr_reg     <= '0;
      result_reg   <= '0;
      addD_out_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            op_reg     <= funct3;
            a_reg      <= dataA;
            b_reg      <= dataB;
            rd_reg     <= addD;
            sa_reg     <= a_sgn_in && dataA[XLEN-1];
            sb_reg     <= b_sgn_in && dataB[XLEN-1];
            cnt_reg    <= '0;
            prod_reg   <= '0;
            mcand_reg  <= {{XLEN{1'b0}}, mag_a_in};
            mplier_reg <= mag_b_in;
            rem_reg    <= '0;
            quo_reg    <= mag_a_in;
            dvsr_reg   <= mag_b_in;
`ifdef MULDIV_EARLY_OUT_EN
            if (special_in) begin
              state_reg    <= ST_DONE;
              result_reg   <= final_result(funct3, dataA, dataB, 1'b0, 1'b0,
                                           '0, '0, '0);
              addD_out_reg <= addD;
            end else begin
              state_reg <= ST_CALC;
            end
`else
            state_reg <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          prod_reg   <= prod_next;
          mcand_reg  <= {mcand_reg[2*XLEN-2:0], 1'b0};
          mplier_reg <= {1'b0, mplier_reg[XLEN-1:1]};
          rem_reg    <= rem_next;
          quo_reg    <= quo_next;
          cnt_reg    <= cnt_reg + 6'd1;
          if (cnt_reg == LAST_ITER) begin
            state_reg    <= ST_DONE;
            result_reg   <= final_result(op_reg, a_reg, b_reg, sa_reg, sb_reg,
                                         prod_next, quo_next, rem_next);
            addD_out_reg <= rd_reg;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state_reg == ST_CALC);
  assign done     = (state_reg == ST_DONE);
  assign result   = result_reg;
  assign addD_out = addD_out_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit -- directed self-checking bench for mul_div_unit.
// Cycle 0 is the cycle in which start is driven high; inputs are driven and
// outputs sampled on the falling edge. Build with MULDIV_EARLY_OUT_EN defined
// to exercise the early-out variant; expected latencies follow the macro.

module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [4:0]  addD;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  addD_out;

  int errors;
  int checks;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 33;
`endif

  mul_div_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .funct3   (funct3),
    .dataA    (dataA),
    .dataB    (dataB),
    .addD     (addD),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .addD_out (addD_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op, scramble the inputs right after acceptance, and check
  // latency, busy profile, result, addD_out, pulse width and hold.
  task automatic run_op(input string name, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res,
                        input int exp_lat);
    int cyc;
    bit busy_ok;
    start = 1'b1; funct3 = f3; dataA = a; dataB = b; addD = rd;
    @(negedge clk);
    start = 1'b0; funct3 = ~f3; dataA = ~a; dataB = a ^ 32'h5A5A_0001; addD = ~rd;
    cyc = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: done not seen within %0d cycles", name, cyc);
      return;
    end
    $display("op %s f3=%0d a=%h b=%h -> result=%h addD_out=%0d cycle=%0d",
             name, f3, a, b, result, addD_out, cyc);
    if (cyc !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_lat);
    end
    checks++;
    if (result !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, result, exp_res);
    end
    checks++;
    if (addD_out !== rd) begin
      errors++;
      $display("FAIL %s addD_out: got %0d expected %0d", name, addD_out, rd);
    end
    checks++;
    if (busy !== 1'b0 || busy_ok !== 1'b1) begin
      errors++;
      $display("FAIL %s busy: at done %b, high-throughout %b expected 0/1",
               name, busy, busy_ok);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== exp_res) begin
      errors++;
      $display("FAIL %s pulse/hold: done=%b result=%h expected 0/%h",
               name, done, result, exp_res);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; funct3 = 3'd0; dataA = '0; dataB = '0; addD = '0;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || addD_out !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b result=%h addD_out=%0d expected all 0",
               busy, done, result, addD_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // first start accepted on the very first edge with reset released
    run_op("MUL_first", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33);
  endtask

  task automatic test_mul();
    run_op("MUL",    3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
    run_op("MULHU",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  32'hFFFF_FFFE, 33);
    run_op("MULH",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000, 33);
    // -1 (signed) * 0xFFFFFFFF (unsigned) = -(2^32-1) -> high word FFFFFFFF
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFF, 33);
  endtask

  task automatic test_div();
    run_op("DIV",  3'd4, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFD, 33);
    run_op("REM",  3'd6, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFF, 33);
    run_op("DIVU", 3'd5, 32'd100,       32'd7, 5'd14, 32'd14,        33);
    run_op("REMU", 3'd7, 32'd100,       32'd7, 5'd15, 32'd2,         33);
  endtask

  task automatic test_div_special();
    run_op("DIVU_by0", 3'd5, 32'd10, 32'd0, 5'd16, 32'hFFFF_FFFF, SPECIAL_LAT);
    run_op("REMU_by0", 3'd7, 32'd10, 32'd0, 5'd17, 32'd10,        SPECIAL_LAT);
    run_op("DIV_by0_neg", 3'd4, 32'hFFFF_FFF9, 32'd0, 5'd18, 32'hFFFF_FFFF, SPECIAL_LAT);
    run_op("DIV_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, SPECIAL_LAT);
    run_op("REM_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h0,         SPECIAL_LAT);
  endtask

  // start pulses during CALC and DONE must neither restart nor queue.
  task automatic test_start_ignored();
    int cyc;
    bit extra_done;
    start = 1'b1; funct3 = 3'd5; dataA = 32'd1000; dataB = 32'd10; addD = 5'd21;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      if (cyc == 5) begin
        start = 1'b1; funct3 = 3'd0; dataA = 32'd3; dataB = 32'd3; addD = 5'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b1;               // held high through the DONE cycle
    funct3 = 3'd0; dataA = 32'd3; dataB = 32'd3; addD = 5'd1;
    $display("op start_ignored DIVU 1000/10 -> result=%h addD_out=%0d cycle=%0d",
             result, addD_out, cyc);
    checks++;
    if (cyc !== 33 || result !== 32'd100 || addD_out !== 5'd21) begin
      errors++;
      $display("FAIL start_ignored: cycle=%0d result=%h rd=%0d expected 33/%h/21",
               cyc, result, addD_out, 32'd100);
    end
    @(negedge clk);
    start = 1'b0;
    extra_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) extra_done = 1'b1;
    end
    checks++;
    if (extra_done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done_ignored: activity seen=%b expected 0", extra_done);
    end
  endtask

  // Reset mid-CALC aborts; no done afterwards; next op runs normally.
  task automatic test_reset_abort();
    bit seen;
    start = 1'b1; funct3 = 3'd0; dataA = 32'd6; dataB = 32'd7; addD = 5'd22;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("op reset_abort at cycle 10 -> busy=%b done=%b result=%h", busy, done, result);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || addD_out !== 5'd0) begin
      errors++;
      $display("FAIL reset_abort_state: busy=%b done=%b result=%h addD_out=%0d expected all 0",
               busy, done, result, addD_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_no_done: activity seen=%b expected 0", seen);
    end
    run_op("MUL_after_reset", 3'd0, 32'd6, 32'd7, 5'd23, 32'd42, 33);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_start_ignored();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request an operation; sampled only in IDLE.
REQ-005 SHALL have port funct3  input  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have port dataA  input  32  rs1 operand from register file.
REQ-007 SHALL have port dataB  input  32  rs2 operand from register file.
REQ-008 SHALL have port addD  input  5  destination register index for this op.
REQ-009 SHALL have port busy  output  1  high while iterating (CALC).
REQ-010 SHALL have port done  output  1  one-cycle pulse: result valid.
REQ-011 SHALL have port result  output  32  write-back value for the register file.
REQ-012 SHALL have port addD_out  output  5  addD latched at start, valid with done.

Function
REQ-013 SHALL implement states IDLE, CALC, DONE; IDLE->CALC on start; CALC->DONE after 32 iterations; DONE->IDLE unconditionally.
REQ-014 SHALL latch funct3, dataA, dataB, addD on the edge that accepts start; later input changes SHALL NOT affect the operation.
REQ-015 SHALL ignore start in CALC and DONE (no queueing, no restart).
REQ-016 Latency: start high in cycle 0 -> busy high cycles 1..32, done high exactly cycle 33, busy low in cycle 33.
REQ-017 SHALL multiply by iterative shift-add over 32 cycles on sign-adjusted magnitudes, 64-bit product; MUL returns bits 31:0, MULH/MULHSU/MULHU bits 63:32.
REQ-018 Signedness: MULH both signed; MULHSU dataA signed, dataB unsigned; MULHU both unsigned; DIV/REM signed; DIVU/REMU unsigned.
REQ-019 SHALL divide by restoring division, one quotient bit per CALC cycle; signed ops: quotient negated if operand signs differ, remainder takes dividend sign.
REQ-020 Divide by zero: quotient = 32'hFFFFFFFF, remainder = dataA; no exception.
REQ-021 Signed overflow (dataA = 32'h80000000, dataB = 32'hFFFFFFFF, DIV/REM): quotient = 32'h80000000, remainder = 0.
REQ-022 result and addD_out SHALL update on entry to DONE and hold until the next DONE entry.
REQ-023 SHALL use a 6-bit iteration counter, cleared on start, terminating at 32; no wrap into a 33rd iteration.

Reset
REQ-024 rst_n low SHALL force state IDLE, busy=0, done=0, result=0, addD_out=0, counter=0 immediately, regardless of clock.
REQ-025 Reset during CALC or DONE SHALL abort the operation; no done pulse SHALL follow release.
REQ-026 First start SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-027 Macro MULDIV_EARLY_OUT_EN SHALL, when defined, make divide-by-zero and signed-overflow ops skip CALC: IDLE->DONE, done in cycle 1, busy never asserted.
REQ-028 Without MULDIV_EARLY_OUT_EN, those cases SHALL take the full 33-cycle latency with results per REQ-020/021.

Verification
REQ-029 MUL dataA=7, dataB=-3 (32'hFFFFFFFD), addD=5 -> done cycle 33, result=32'hFFFFFFEB, addD_out=5.
REQ-030 MULHU dataA=dataB=32'hFFFFFFFF -> result=32'hFFFFFFFE; MULH same operands -> result=0.
REQ-031 DIV dataA=-7, dataB=2 -> result=32'hFFFFFFFD; REM same -> result=32'hFFFFFFFF.
REQ-032 DIVU dataA=10, dataB=0 -> result=32'hFFFFFFFF; REMU -> result=10; done cycle 1 with MULDIV_EARLY_OUT_EN, cycle 33 without.
REQ-033 DIV 32'h80000000 / 32'hFFFFFFFF -> result=32'h80000000; REM -> 0.
REQ-034 start during CALC ignored; rst_n low at cycle 10 -> busy=0, done never pulses; new start after release completes normally.
